// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - CPU request/response and RAM bus bundle for cache_controller
interface cache_controller_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_ready;
    logic [WIDTH-1:0]  cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_wdone;
    logic              cpu_hit;
    logic              flush;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_rvalid;

    // master: requester plus RAM side; slave: the cache controller
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_rvalid,
        input  cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone, cpu_hit,
               mem_addr, mem_wdata, mem_we, mem_re
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_rvalid,
        output cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone, cpu_hit,
               mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through no-write-allocate cache controller
module cache_controller #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 4,
    parameter int INDEX_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    cache_controller_if.slave bus,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

    state_t                         state_q, state_d;
    logic                           req_we_q, req_we_d;
    logic [ADDR_W-1:0]              req_addr_q, req_addr_d;
    logic [WIDTH-1:0]               req_wdata_q, req_wdata_d;
    logic                           hit_q, hit_d;
    logic [LINES-1:0]               valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [LINES-1:0][WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]               cpu_rdata_q, cpu_rdata_d;
    logic                           cpu_rvalid_q, cpu_rvalid_d;
    logic                           cpu_wdone_q, cpu_wdone_d;
    logic                           cpu_hit_q, cpu_hit_d;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]               mem_wdata_q, mem_wdata_d;
    logic                           mem_we_q, mem_we_d;
    logic                           mem_re_q, mem_re_d;
    logic [15:0]                    hit_cnt_q, hit_cnt_d;
    logic [15:0]                    miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               lookup_hit;

    assign req_index  = req_addr_q[INDEX_W-1:0];
    assign req_tag    = req_addr_q[ADDR_W-1:INDEX_W];
    assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        hit_d        = hit_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        cpu_wdone_d  = 1'b0;
        cpu_hit_d    = cpu_hit_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.cpu_req) begin
                    req_we_d    = bus.cpu_we;
                    req_addr_d  = bus.cpu_addr;
                    req_wdata_d = bus.cpu_wdata;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d = lookup_hit;
                if (lookup_hit) begin
                    hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
                end else begin
                    miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                end
                mem_addr_d = req_addr_q;
                if (req_we_q) begin
                    // write-through always; a miss leaves the line untouched
                    mem_wdata_d = req_wdata_q;
                    mem_we_d    = 1'b1;
                    if (lookup_hit) begin
                        data_d[req_index] = req_wdata_q;
                    end
                    state_d = WRITE;
                end else if (lookup_hit) begin
                    cpu_rdata_d  = data_q[req_index];
                    cpu_rvalid_d = 1'b1;
                    cpu_hit_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    mem_re_d = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (bus.mem_rvalid) begin
                    data_d[req_index]  = bus.mem_rdata;
                    tag_d[req_index]   = req_tag;
                    valid_d[req_index] = 1'b1;
                    cpu_rdata_d        = bus.mem_rdata;
                    cpu_rvalid_d       = 1'b1;
                    cpu_hit_d          = 1'b0;
                    state_d            = IDLE;
                end
            end
            WRITE: begin
                cpu_wdone_d = 1'b1;
                cpu_hit_d   = hit_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            hit_q        <= 1'b0;
            valid_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_wdone_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            hit_q        <= hit_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_wdone_q  <= cpu_wdone_d;
            cpu_hit_q    <= cpu_hit_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bus.cpu_ready  = (state_q == IDLE) && !bus.flush;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_wdone  = cpu_wdone_q;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed vector bench for cache_controller with a 16-word RAM model
module tb_cache_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cache_controller_if #(.WIDTH(32), .ADDR_W(4)) bus ();

    cache_controller #(.WIDTH(32), .ADDR_W(4), .INDEX_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: 1-cycle registered read; valid deliberately not cleared by reset
    logic [31:0] ram [16];
    always @(posedge clk) begin
        bus.mem_rvalid <= (bus.mem_re === 1'b1);
        if (bus.mem_re === 1'b1) bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) check("mem_re_we_exclusive", 32'(bus.mem_re && bus.mem_we), 32'd0);
    end

    typedef struct {
        bit          flush;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        bit          exp_hit;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    vec_t vecs [17];

    int          got_lat;
    logic        got_hit;
    logic        got_ready;
    logic [31:0] got_rdata;
    int          got_re_n;
    int          got_we_n;
    logic [3:0]  got_maddr;
    logic [31:0] got_mwdata;

    task automatic run_req(input bit fl, input bit we, input logic [3:0] addr, input logic [31:0] wd);
        int n;
        @(negedge clk);
        if (fl) begin
            bus.flush = 1'b1;
            #1;
            check("ready_during_flush", 32'(bus.cpu_ready), 32'd0);
            @(negedge clk);
            bus.flush = 1'b0;
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        #1;
        n = 0;
        while (!bus.cpu_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready_at_issue", 32'(bus.cpu_ready), 32'd1);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        got_lat = -1; got_re_n = 0; got_we_n = 0;
        got_hit = 1'bx; got_rdata = 'x; got_maddr = 'x; got_mwdata = 'x; got_ready = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.mem_re) begin got_re_n++; got_maddr = bus.mem_addr; end
            if (bus.mem_we) begin got_we_n++; got_maddr = bus.mem_addr; got_mwdata = bus.mem_wdata; end
            if (bus.cpu_rvalid || bus.cpu_wdone) begin
                got_lat   = k;
                got_hit   = bus.cpu_hit;
                got_rdata = bus.cpu_rdata;
                got_ready = bus.cpu_ready;
                if (we) check("resp_kind_wdone", 32'(bus.cpu_wdone), 32'd1);
                else    check("resp_kind_rvalid", 32'(bus.cpu_rvalid), 32'd1);
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        //           fl we addr   wdata         hit rdata        lat h  m
        vecs[0]  = '{0, 0, 4'h5, 32'h0,        0, 32'h0,        3, 0, 1};
        vecs[1]  = '{0, 0, 4'h5, 32'h0,        1, 32'h0,        1, 1, 1};
        vecs[2]  = '{0, 1, 4'h5, 32'hDEADBEEF, 1, 32'h0,        2, 2, 1};
        vecs[3]  = '{0, 0, 4'h5, 32'h0,        1, 32'hDEADBEEF, 1, 3, 1};
        vecs[4]  = '{0, 1, 4'h9, 32'h12345678, 0, 32'h0,        2, 3, 2};
        vecs[5]  = '{0, 0, 4'h5, 32'h0,        1, 32'hDEADBEEF, 1, 4, 2};
        vecs[6]  = '{0, 0, 4'h9, 32'h0,        0, 32'h12345678, 3, 4, 3};
        vecs[7]  = '{0, 0, 4'h5, 32'h0,        0, 32'hDEADBEEF, 3, 4, 4};
        vecs[8]  = '{0, 0, 4'h9, 32'h0,        0, 32'h12345678, 3, 4, 5};
        vecs[9]  = '{0, 0, 4'h9, 32'h0,        1, 32'h12345678, 1, 5, 5};
        vecs[10] = '{1, 0, 4'h9, 32'h0,        0, 32'h12345678, 3, 5, 6};
        vecs[11] = '{0, 1, 4'hE, 32'hA5A5A5A5, 0, 32'h0,        2, 5, 7};
        vecs[12] = '{0, 0, 4'hE, 32'h0,        0, 32'hA5A5A5A5, 3, 5, 8};
        vecs[13] = '{0, 0, 4'h2, 32'h0,        0, 32'h0,        3, 5, 9};
        vecs[14] = '{0, 0, 4'hE, 32'h0,        0, 32'hA5A5A5A5, 3, 5, 10};
        vecs[15] = '{0, 1, 4'hE, 32'h0F0F0F0F, 1, 32'h0,        2, 6, 10};
        vecs[16] = '{0, 0, 4'hE, 32'h0,        1, 32'h0F0F0F0F, 1, 7, 10};

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rvalid",   32'(bus.cpu_rvalid), 32'd0);
        check("reset_wdone",    32'(bus.cpu_wdone),  32'd0);
        check("reset_mem_re",   32'(bus.mem_re),     32'd0);
        check("reset_mem_we",   32'(bus.mem_we),     32'd0);
        check("reset_hit_cnt",  32'(hit_cnt),        32'd0);
        check("reset_miss_cnt", 32'(miss_cnt),       32'd0);
        check("reset_ready",    32'(bus.cpu_ready),  32'd1);

        for (int i = 0; i < 17; i++) begin
            run_req(vecs[i].flush, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_hit", i), 32'(got_hit), 32'(vecs[i].exp_hit));
            check($sformatf("v%0d_ready_at_resp", i), 32'(got_ready), 32'd1);
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_hit_cnt", i), 32'(hit_cnt), 32'(vecs[i].exp_hits));
            check($sformatf("v%0d_miss_cnt", i), 32'(miss_cnt), 32'(vecs[i].exp_misses));
            check($sformatf("v%0d_mem_re_pulses", i), 32'(got_re_n),
                  32'((!vecs[i].we && !vecs[i].exp_hit) ? 1 : 0));
            check($sformatf("v%0d_mem_we_pulses", i), 32'(got_we_n), 32'(vecs[i].we ? 1 : 0));
            if (vecs[i].we || !vecs[i].exp_hit)
                check($sformatf("v%0d_mem_addr", i), 32'(got_maddr), 32'(vecs[i].addr));
            if (vecs[i].we)
                check($sformatf("v%0d_mem_wdata", i), got_mwdata, vecs[i].wdata);
        end
        check("ram_0x9_written", ram[9], 32'h12345678);

        // reset while FILL is pending; the RAM still returns a late valid
        begin
            int late_rvalid;
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'hA;
            @(negedge clk);
            bus.cpu_req = 1'b0;
            @(negedge clk);
            check("rst_fill_mem_re", 32'(bus.mem_re), 32'd1);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rst_cpu_rdata",  bus.cpu_rdata,        32'd0);
            check("rst_cpu_rvalid", 32'(bus.cpu_rvalid),  32'd0);
            check("rst_cpu_wdone",  32'(bus.cpu_wdone),   32'd0);
            check("rst_cpu_hit",    32'(bus.cpu_hit),     32'd0);
            check("rst_mem_addr",   32'(bus.mem_addr),    32'd0);
            check("rst_mem_wdata",  bus.mem_wdata,        32'd0);
            check("rst_mem_we",     32'(bus.mem_we),      32'd0);
            check("rst_mem_re",     32'(bus.mem_re),      32'd0);
            check("rst_hit_cnt",    32'(hit_cnt),         32'd0);
            check("rst_miss_cnt",   32'(miss_cnt),        32'd0);
            check("rst_ready",      32'(bus.cpu_ready),   32'd1);
            late_rvalid = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.cpu_rvalid || bus.cpu_wdone) late_rvalid++;
            end
            check("rst_no_cpu_response", 32'(late_rvalid), 32'd0);
        end

        run_req(1'b0, 1'b0, 4'hA, 32'h0);
        check("post_rst_latency",  32'(got_lat),  32'd3);
        check("post_rst_hit",      32'(got_hit),  32'd0);
        check("post_rst_rdata",    got_rdata,     32'd0);
        check("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);
        check("post_rst_hit_cnt",  32'(hit_cnt),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
